// File: rtl/program_loader.sv
// program_loader
// Boot-time image loader. Takes a byte stream over a valid/ready handshake,
// assembles big-endian 16-bit words and writes them to consecutive memory
// addresses starting at BASE_ADDR. The datapath is held in reset (CPUHold)
// until the trailing XOR checksum byte has been matched.
//
// Stream: CNT_HI, CNT_LO, N x (DAT_HI, DAT_LO), CHK
//   CHK = XOR of every preceding byte, count bytes included.
//
// Ports
//   CLK        in   1   system clock, rising edge
//   RST_n      in   1   synchronous active-low reset
//   ByteIn     in   8   stream byte
//   ByteValid  in   1   ByteIn valid
//   ByteReady  out  1   loader can accept a byte
//   MemAddr    out  16  memory write address (registered)
//   MemDataIn  out  16  memory write data (registered)
//   MemWrite   out  1   write strobe, one cycle per word
//   CPUHold    out  1   holds datapath/control FSM in reset
//   Done       out  1   image loaded and verified (sticky until reset)
//   Error      out  1   oversize count or bad checksum (sticky until reset)
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_CNT_HI | waiting for word count high byte
// S_CNT_LO | waiting for word count low byte, range-check the count
// S_DAT_HI | waiting for data word high byte
// S_DAT_LO | waiting for data word low byte, load address/data
// S_WRITE  | one-cycle memory write strobe, advance word index
// S_CHECK  | waiting for checksum byte
// S_DONE   | image verified, datapath released
// S_ERROR  | load rejected, datapath held
module program_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int unsigned MEM_DEPTH = 1024
) (
   input  logic        CLK,
   input  logic        RST_n,
   input  logic [7:0]  ByteIn,
   input  logic        ByteValid,
   output logic        ByteReady,
   output logic [15:0] MemAddr,
   output logic [15:0] MemDataIn,
   output logic        MemWrite,
   output logic        CPUHold,
   output logic        Done,
   output logic        Error
);

   typedef enum logic [2:0] {
      S_CNT_HI,
      S_CNT_LO,
      S_DAT_HI,
      S_DAT_LO,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   // 17 bits so a depth of 65536 still compares correctly against a 16-bit count
   localparam logic [16:0] DEPTH_LIMIT = 17'(MEM_DEPTH);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] idx_q, idx_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic [7:0]  hi_q, hi_d;
   logic [7:0]  xor_q, xor_d;

   logic        ready_state;
   logic        accept;
   logic [15:0] cnt_full;
   logic [15:0] idx_inc;

   always_comb begin
      ready_state = 1'b0;
      case (state_q)
         S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO, S_CHECK: ready_state = 1'b1;
         default:                                         ready_state = 1'b0;
      endcase
   end

   // Gated by RST_n so the sender never sees ready while reset is asserted
   assign ByteReady = ready_state & RST_n;
   assign accept    = ByteValid & ByteReady;
   assign cnt_full  = {cnt_q[15:8], ByteIn};
   assign idx_inc   = idx_q + 16'd1;

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state_q <= S_CNT_HI;
         cnt_q   <= 16'h0000;
         idx_q   <= 16'h0000;
         addr_q  <= BASE_ADDR;
         data_q  <= 16'h0000;
         hi_q    <= 8'h00;
         xor_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         hi_q    <= hi_d;
         xor_q   <= xor_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      data_d  = data_q;
      hi_d    = hi_q;
      xor_d   = xor_q;

      case (state_q)
         S_CNT_HI: begin
            if (accept) begin
               cnt_d   = {ByteIn, cnt_q[7:0]};
               xor_d   = xor_q ^ ByteIn;
               state_d = S_CNT_LO;
            end
         end
         S_CNT_LO: begin
            if (accept) begin
               cnt_d = cnt_full;
               xor_d = xor_q ^ ByteIn;
               if ({1'b0, cnt_full} > DEPTH_LIMIT) begin
                  state_d = S_ERROR;
               end else if (cnt_full == 16'h0000) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_DAT_HI;
               end
            end
         end
         S_DAT_HI: begin
            if (accept) begin
               hi_d    = ByteIn;
               xor_d   = xor_q ^ ByteIn;
               state_d = S_DAT_LO;
            end
         end
         S_DAT_LO: begin
            if (accept) begin
               data_d  = {hi_q, ByteIn};
               addr_d  = BASE_ADDR + idx_q;
               xor_d   = xor_q ^ ByteIn;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            idx_d = idx_inc;
            if (idx_inc == cnt_q) begin
               state_d = S_CHECK;
            end else begin
               state_d = S_DAT_HI;
            end
         end
         S_CHECK: begin
            // checksum byte itself is not folded into the running XOR
            if (accept) begin
               state_d = (ByteIn == xor_q) ? S_DONE : S_ERROR;
            end
         end
         S_DONE:  state_d = S_DONE;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_ERROR;
      endcase
   end

   assign MemAddr   = addr_q;
   assign MemDataIn = data_q;
   assign MemWrite  = (state_q == S_WRITE);
   assign Done      = (state_q == S_DONE);
   assign Error     = (state_q == S_ERROR);
   assign CPUHold   = (state_q != S_DONE);

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

   localparam int          DEPTH = 1024;
   localparam logic [15:0] BASE  = 16'h0000;

   logic        CLK = 1'b0;
   logic        RST_n = 1'b0;
   logic [7:0]  ByteIn = 8'h00;
   logic        ByteValid = 1'b0;
   logic        ByteReady;
   logic [15:0] MemAddr;
   logic [15:0] MemDataIn;
   logic        MemWrite;
   logic        CPUHold;
   logic        Done;
   logic        Error;

   program_loader #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .ByteIn    (ByteIn),
      .ByteValid (ByteValid),
      .ByteReady (ByteReady),
      .MemAddr   (MemAddr),
      .MemDataIn (MemDataIn),
      .MemWrite  (MemWrite),
      .CPUHold   (CPUHold),
      .Done      (Done),
      .Error     (Error)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   logic [31:0] got[$];

   // edges since reset release
   always @(posedge CLK) begin
      if (!RST_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge CLK) begin
      if (MemWrite === 1'b1) got.push_back({MemAddr, MemDataIn});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: interpret the byte list directly.
   task automatic model(input logic [7:0] s[$], output logic [31:0] ew[$],
                        output bit ed, output bit ee);
      int n;
      logic [7:0] x;
      ew.delete();
      ed = 1'b0;
      ee = 1'b0;
      n  = {s[0], s[1]};
      if (n > DEPTH) begin
         ee = 1'b1;
      end else begin
         x = 8'h00;
         for (int i = 0; i < 2 + 2 * n; i++) x = x ^ s[i];
         for (int k = 0; k < n; k++)
            ew.push_back({BASE + 16'(k), s[2 + 2 * k], s[3 + 2 * k]});
         if (s[2 + 2 * n] == x) ed = 1'b1;
         else                   ee = 1'b1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int gap;
      int guard;
      bit acc;
      gap = int'($urandom_range(0, maxgap));
      repeat (gap) begin
         ByteValid = 1'b0;
         @(negedge CLK);
      end
      ByteValid = 1'b1;
      ByteIn    = b;
      guard     = 0;
      forever begin
         #1;
         acc = ByteReady;
         @(negedge CLK);
         if (acc) break;
         guard++;
         if (guard > 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: byte %h not accepted within 50 cycles", b);
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_n     = 1'b0;
      ByteValid = 1'b0;
      repeat (2) @(negedge CLK);
      check("rst_ready",   ByteReady, 0);
      check("rst_hold",    CPUHold,   1);
      check("rst_done",    Done,      0);
      check("rst_error",   Error,     0);
      check("rst_memwr",   MemWrite,  0);
      check("rst_addr",    MemAddr,   BASE);
      check("rst_data",    MemDataIn, 0);
      RST_n = 1'b1;
      #1;
      got.delete();
      check("release_ready", ByteReady, 1);
   endtask

   task automatic run_stream(input logic [7:0] s[$], input int maxgap, input string tag,
                             output bit d, output bit e, output int nw, output int cycles);
      logic [31:0] ew[$];
      bit ed, ee;
      do_reset();
      for (int i = 0; i < s.size(); i++) send_byte(s[i], maxgap);
      cycles    = cyc;
      ByteValid = 1'b0;
      model(s, ew, ed, ee);
      check({tag, "_done_now"},  Done,      ed);
      check({tag, "_error_now"}, Error,     ee);
      check({tag, "_ready_now"}, ByteReady, 0);
      // sender keeps offering a byte; it must be refused
      ByteValid = 1'b1;
      ByteIn    = 8'h5A;
      repeat (3) @(negedge CLK);
      ByteValid = 1'b0;
      check({tag, "_ready_after"}, ByteReady, 0);
      check({tag, "_done"},        Done,      ed);
      check({tag, "_error"},       Error,     ee);
      check({tag, "_hold"},        CPUHold,   !ed);
      check({tag, "_nwrites"},     got.size(), ew.size());
      for (int k = 0; k < ew.size() && k < got.size(); k++)
         check({tag, "_write"}, got[k], ew[k]);
      d  = Done;
      e  = Error;
      nw = got.size();
   endtask

   typedef struct {
      logic [63:0] bytes;
      int          len;
      int          maxgap;
      bit          exp_done;
      bit          exp_err;
      int          exp_writes;
   } vec_t;

   vec_t tv[5];

   initial begin
      logic [7:0] s[$];
      bit d, e;
      int nw, cycles;
      int n, kind, maxgap;
      logic [7:0] x;

      tv[0] = '{64'h0002_1234_ABCD_4200, 7, 0, 1'b1, 1'b0, 2};
      tv[1] = '{64'h0002_1234_ABCD_4300, 7, 0, 1'b0, 1'b1, 2};
      tv[2] = '{64'h0000_0000_0000_0000, 3, 0, 1'b1, 1'b0, 0};
      tv[3] = '{64'h0401_0000_0000_0000, 2, 0, 1'b0, 1'b1, 0};
      tv[4] = '{64'h0002_1234_ABCD_4200, 7, 5, 1'b1, 1'b0, 2};

      for (int i = 0; i < 5; i++) begin
         s.delete();
         for (int j = 0; j < tv[i].len; j++) s.push_back(tv[i].bytes[63 - 8 * j -: 8]);
         run_stream(s, tv[i].maxgap, $sformatf("vec%0d", i), d, e, nw, cycles);
         check("vec_done",   d,  tv[i].exp_done);
         check("vec_error",  e,  tv[i].exp_err);
         check("vec_writes", nw, tv[i].exp_writes);
         if (tv[i].maxgap == 0)
            check("vec_cycles", cycles, tv[i].len + tv[i].exp_writes);
      end

      // explicit writes of the reference stream
      s.delete();
      s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
      run_stream(s, 0, "ref", d, e, nw, cycles);
      check("ref_w0", (got.size() > 0) ? got[0] : 32'hFFFF_FFFF, 32'h0000_1234);
      check("ref_w1", (got.size() > 1) ? got[1] : 32'hFFFF_FFFF, 32'h0001_ABCD);
      check("ref_cycle9", cycles, 9);

      // reset pulse right after the first write strobe
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      check("mid_memwrite", MemWrite, 1);
      check("mid_wr_val",   {MemAddr, MemDataIn}, 32'h0000_1234);
      RST_n     = 1'b0;
      ByteValid = 1'b0;
      @(negedge CLK);
      check("mid_rst_hold",  CPUHold,   1);
      check("mid_rst_ready", ByteReady, 0);
      check("mid_rst_mw",    MemWrite,  0);
      check("mid_rst_data",  MemDataIn, 0);
      RST_n = 1'b1;
      #1;
      got.delete();
      check("mid_rel_hold", CPUHold, 1);
      for (int i = 0; i < s.size(); i++) send_byte(s[i], 0);
      ByteValid = 1'b0;
      check("mid_reload_w0", (got.size() > 0) ? got[0] : 32'hFFFF_FFFF, 32'h0000_1234);
      check("mid_reload_n",  got.size(), 2);
      check("mid_reload_done", Done, 1);
      check("mid_reload_hold", CPUHold, 0);

      // randomized streams against the reference model
      for (int r = 0; r < 25; r++) begin
         s.delete();
         n    = int'($urandom_range(0, 5));
         kind = int'($urandom_range(0, 7));
         if (kind == 0) n = DEPTH + 1 + int'($urandom_range(0, 3));
         maxgap = int'($urandom_range(0, 3));
         s.push_back(8'(n >> 8));
         s.push_back(8'(n));
         if (n <= DEPTH) begin
            for (int k = 0; k < 2 * n; k++) s.push_back(8'($urandom));
            x = 8'h00;
            foreach (s[k]) x = x ^ s[k];
            if (kind == 1) x = x ^ (8'h01 << $urandom_range(0, 7));
            s.push_back(x);
         end
         run_stream(s, maxgap, $sformatf("rnd%0d", r), d, e, nw, cycles);
      end

      // largest accepted image
      s.delete();
      s.push_back(8'(DEPTH >> 8));
      s.push_back(8'(DEPTH));
      for (int k = 0; k < 2 * DEPTH; k++) s.push_back(8'($urandom));
      x = 8'h00;
      foreach (s[k]) x = x ^ s[k];
      s.push_back(x);
      run_stream(s, 0, "full", d, e, nw, cycles);
      check("full_cycles", cycles, 2 + 3 * DEPTH + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
